// File: rtl/priority_code_decoder_if.sv
// Request/decoded-output bundle for priority_code_decoder.
// The master side drives the encoded request; the slave side is the decoder.
interface priority_code_decoder_if;
    logic [1:0] A;
    logic       v;
    logic       in_ready;
    logic [3:0] D;
    logic       d_valid;
    logic       busy;

    modport master (output A, output v, input in_ready, input D, input d_valid, input busy);
    modport slave  (input A, input v, output in_ready, output D, output d_valid, output busy);
endinterface

// File: rtl/priority_code_decoder.sv
// Decodes a 2-bit request index into a one-hot line held for HOLD cycles,
// followed by one idle gap cycle, with a single-entry pending slot.
module priority_code_decoder #(
    parameter int HOLD = 4,
    parameter int CW   = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    priority_code_decoder_if.slave  bus
);

    localparam logic [1:0]    IDLE    = 2'd0;
    localparam logic [1:0]    DRIVE   = 2'd1;
    localparam logic [1:0]    GAP     = 2'd2;
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

    logic [1:0]    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    cur_code_r, cur_code_s;
    logic [1:0]    pend_code_r, pend_code_s;
    logic          pend_full_r, pend_full_s;
    logic [3:0]    d_r;
    logic          d_valid_r;
    logic          busy_r;
    logic          accept_s;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        logic [3:0] res;
        case (code)
            2'b00:   res = 4'b0001;
            2'b01:   res = 4'b0010;
            2'b10:   res = 4'b0100;
            2'b11:   res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    assign bus.in_ready = rst_n & ~pend_full_r;
    assign accept_s     = bus.v & bus.in_ready;

    assign bus.D        = d_r;
    assign bus.d_valid  = d_valid_r;
    assign bus.busy     = busy_r;

    // Next-state logic for the drive/gap sequencer and pending slot.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        cur_code_s  = cur_code_r;
        pend_code_s = pend_code_r;
        pend_full_s = pend_full_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cur_code_s = bus.A;
                    cnt_s      = HOLD_M1;
                    state_s    = DRIVE;
                end else begin
                    state_s    = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = GAP;
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
                if (accept_s) begin
                    pend_code_s = bus.A;
                    pend_full_s = 1'b1;
                end else begin
                    pend_full_s = pend_full_r;
                end
            end
            GAP: begin
                // A code accepted during an empty-slot gap goes straight to
                // DRIVE, which is the same timing as parking it in pending.
                if (pend_full_r) begin
                    cur_code_s  = pend_code_r;
                    pend_full_s = 1'b0;
                    cnt_s       = HOLD_M1;
                    state_s     = DRIVE;
                end else if (accept_s) begin
                    cur_code_s  = bus.A;
                    cnt_s       = HOLD_M1;
                    state_s     = DRIVE;
                end else begin
                    state_s     = IDLE;
                end
            end
            default: begin
                state_s     = IDLE;
                pend_full_s = 1'b0;
            end
        endcase
    end

    // State, storage and registered outputs; outputs reflect the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            cur_code_r  <= 2'b00;
            pend_code_r <= 2'b00;
            pend_full_r <= 1'b0;
            d_r         <= 4'b0000;
            d_valid_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_code_r  <= cur_code_s;
            pend_code_r <= pend_code_s;
            pend_full_r <= pend_full_s;
            d_r         <= (state_s == DRIVE) ? onehot(cur_code_s) : 4'b0000;
            d_valid_r   <= (state_s == DRIVE);
            busy_r      <= (state_s != IDLE) | pend_full_s;
        end
    end

endmodule

// File: tb/tb_priority_code_decoder.sv
// Bench for priority_code_decoder: directed vector table on HOLD=4, a short
// HOLD=1 sequence, and random traffic on both checked against a slot model.
module tb_priority_code_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    priority_code_decoder_if bus0 ();
    priority_code_decoder_if bus1 ();

    priority_code_decoder #(.HOLD(4), .CW(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    priority_code_decoder #(.HOLD(1), .CW(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        bit         r;
        bit         v;
        logic [1:0] a;
        logic [3:0] d;
        bit         dv;
        bit         b;
        bit         rdy;
    } vec_t;

    vec_t tbl [32];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: each accepted code occupies a slot of HOLD+1 cycles (HOLD driven,
    // one gap); one further code may wait for the current slot to finish.
    int hold [2] = '{4, 1};
    int rem  [2];
    int cur  [2];
    bit wv   [2];
    int wc   [2];
    bit rst_m;

    function automatic vec_t mk(bit r, bit v, logic [1:0] a, logic [3:0] d, bit dv, bit b, bit rdy);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.d = d; t.dv = dv; t.b = b; t.rdy = rdy;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [1:0] a);
        bit acc;
        rst_m = r;
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                rem[k] = 0;
                wv[k]  = 1'b0;
            end else begin
                acc = v && !wv[k];
                if (rem[k] > 0) rem[k]--;
                if (acc) begin
                    wv[k] = 1'b1;
                    wc[k] = int'(a);
                end
                if (rem[k] == 0 && wv[k]) begin
                    cur[k] = wc[k];
                    wv[k]  = 1'b0;
                    rem[k] = hold[k] + 1;
                end
            end
        end
    endtask

    task automatic check_dut(input string n, input int k, input logic [3:0] d,
                             input logic dv, input logic b, input logic rdy);
        logic [3:0] exp_d;
        exp_d = (rem[k] > 1) ? 4'(1 << cur[k]) : 4'b0000;
        check({n, ".D"},        32'(d),   32'(exp_d));
        check({n, ".d_valid"},  32'(dv),  32'(rem[k] > 1));
        check({n, ".busy"},     32'(b),   32'((rem[k] > 0) || wv[k]));
        check({n, ".in_ready"}, 32'(rdy), 32'(rst_m && !wv[k]));
        check({n, ".onehot"},   32'($countones(d) <= 1), 32'(1));
        check({n, ".dv_vs_D"},  32'(dv),  32'(d != 4'b0000));
    endtask

    task automatic drive(input bit r, input bit v, input logic [1:0] a);
        rst_n   = r;
        bus0.v  = v; bus0.A = a;
        bus1.v  = v; bus1.A = a;
        @(posedge clk);
        model_step(r, v, a);
        @(negedge clk);
        cyc++;
        check_dut("dut0", 0, bus0.D, bus0.d_valid, bus0.busy, bus0.in_ready);
        check_dut("dut1", 1, bus1.D, bus1.d_valid, bus1.busy, bus1.in_ready);
    endtask

    initial begin
        // single, back-to-back with backpressure, reset mid-drive, ignore
        tbl[0]  = mk(0, 1, 2'b10, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 2'b00, 4'b0000, 0, 0, 1);
        tbl[2]  = mk(1, 1, 2'b10, 4'b0100, 1, 1, 1);
        tbl[3]  = mk(1, 0, 2'b11, 4'b0100, 1, 1, 1);
        tbl[4]  = mk(1, 0, 2'b01, 4'b0100, 1, 1, 1);
        tbl[5]  = mk(1, 0, 2'b00, 4'b0100, 1, 1, 1);
        tbl[6]  = mk(1, 0, 2'b00, 4'b0000, 0, 1, 1);
        tbl[7]  = mk(1, 0, 2'b00, 4'b0000, 0, 0, 1);
        tbl[8]  = mk(1, 1, 2'b00, 4'b0001, 1, 1, 1);
        tbl[9]  = mk(1, 1, 2'b11, 4'b0001, 1, 1, 0);
        tbl[10] = mk(1, 1, 2'b01, 4'b0001, 1, 1, 0);
        tbl[11] = mk(1, 1, 2'b01, 4'b0001, 1, 1, 0);
        tbl[12] = mk(1, 1, 2'b01, 4'b0000, 0, 1, 0);
        tbl[13] = mk(1, 1, 2'b01, 4'b1000, 1, 1, 1);
        tbl[14] = mk(1, 1, 2'b01, 4'b1000, 1, 1, 0);
        tbl[15] = mk(1, 0, 2'b00, 4'b1000, 1, 1, 0);
        tbl[16] = mk(1, 0, 2'b00, 4'b1000, 1, 1, 0);
        tbl[17] = mk(1, 0, 2'b00, 4'b0000, 0, 1, 0);
        tbl[18] = mk(1, 0, 2'b00, 4'b0010, 1, 1, 1);
        tbl[19] = mk(1, 0, 2'b00, 4'b0010, 1, 1, 1);
        tbl[20] = mk(1, 0, 2'b00, 4'b0010, 1, 1, 1);
        tbl[21] = mk(1, 0, 2'b00, 4'b0010, 1, 1, 1);
        tbl[22] = mk(1, 0, 2'b00, 4'b0000, 0, 1, 1);
        tbl[23] = mk(1, 0, 2'b00, 4'b0000, 0, 0, 1);
        tbl[24] = mk(1, 1, 2'b10, 4'b0100, 1, 1, 1);
        tbl[25] = mk(1, 1, 2'b01, 4'b0100, 1, 1, 0);
        tbl[26] = mk(0, 1, 2'b11, 4'b0000, 0, 0, 0);
        tbl[27] = mk(1, 0, 2'b00, 4'b0000, 0, 0, 1);
        tbl[28] = mk(1, 0, 2'b00, 4'b0000, 0, 0, 1);
        tbl[29] = mk(1, 0, 2'b11, 4'b0000, 0, 0, 1);
        tbl[30] = mk(1, 0, 2'b01, 4'b0000, 0, 0, 1);
        tbl[31] = mk(1, 0, 2'b10, 4'b0000, 0, 0, 1);

        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; cur[k] = 0; wv[k] = 1'b0; wc[k] = 0;
        end
        rst_m = 1'b0;

        drive(0, 0, 2'b00);
        drive(0, 0, 2'b00);

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].a);
            check($sformatf("tbl%0d.D", i),        32'(bus0.D),        32'(tbl[i].d));
            check($sformatf("tbl%0d.d_valid", i),  32'(bus0.d_valid),  32'(tbl[i].dv));
            check($sformatf("tbl%0d.busy", i),     32'(bus0.busy),     32'(tbl[i].b));
            check($sformatf("tbl%0d.in_ready", i), 32'(bus0.in_ready), 32'(tbl[i].rdy));
        end

        // HOLD=1: one drive cycle, one gap, then idle
        drive(1, 1, 2'b01);
        check("h1.D_drive",  32'(bus1.D),       32'(4'b0010));
        check("h1.dv_drive", 32'(bus1.d_valid), 32'(1));
        drive(1, 0, 2'b11);
        check("h1.D_gap",    32'(bus1.D),       32'(4'b0000));
        check("h1.busy_gap", 32'(bus1.busy),    32'(1));
        drive(1, 0, 2'b00);
        check("h1.busy_idle", 32'(bus1.busy),   32'(0));

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_code_decoder.md
PRIORITY_CODE_DECODER -- requirements
Module: priority_code_decoder

Interface
REQ-001 The block SHALL provide parameter HOLD, default 4, giving the number of cycles each decoded one-hot output is held asserted (legal range 1..255).
REQ-002 The block SHALL provide parameter CW, default 8, giving the hold-counter width (must satisfy 2^CW > HOLD).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 A  input  2  encoded index of the highest-priority request (00 -> D[0] ... 11 -> D[3]).
REQ-006 v  input  1  A is valid this cycle (request to transfer).
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 D  output  4  decoded one-hot request line.
REQ-009 d_valid  output  1  D holds a decoded code this cycle.
REQ-010 busy  output  1  block not idle (driving, in gap, or holding a pending code).

Function
REQ-011 A code SHALL be accepted on a rising edge where v=1 and in_ready=1; no other condition accepts.
REQ-012 Storage SHALL be one current register (cur_code) and one pending register (pend_code, pend_full).
REQ-013 in_ready SHALL equal rst_n AND NOT pend_full.
REQ-014 FSM states SHALL be IDLE, DRIVE, GAP.
REQ-015 IDLE: D=0000, d_valid=0; on accept, load cur_code from A, load counter with HOLD-1, next state DRIVE.
REQ-016 DRIVE: D = one-hot of cur_code (00->0001, 01->0010, 10->0100, 11->1000), d_valid=1; counter decrements each cycle; on counter==0 next state GAP.
REQ-017 Accept in DRIVE or GAP SHALL write A into pend_code and set pend_full.
REQ-018 GAP: exactly one cycle, D=0000, d_valid=0; exit to DRIVE loading cur_code from pend_code (pend_full cleared, counter=HOLD-1) if pend_full, else exit to IDLE.
REQ-019 Accept coinciding with counter==0 in DRIVE SHALL be stored in pending and served after the GAP cycle.
REQ-020 Latency: code accepted at edge N SHALL appear on D during cycles N+1..N+HOLD, GAP at N+HOLD+1, busy=0 at N+HOLD+2 if nothing pending.
REQ-021 HOLD=1 SHALL give one DRIVE cycle followed by one GAP cycle.
REQ-022 D, d_valid and busy SHALL be driven from registers only; no combinational path from A or v.
REQ-023 D SHALL never have more than one bit set; d_valid=1 iff exactly one bit of D set.
REQ-024 busy SHALL equal (state != IDLE) OR pend_full.
REQ-025 A with v=0, or with in_ready=0, SHALL have no effect on any state.

Reset
REQ-026 On rising edge with rst_n=0: state=IDLE, counter=0, cur_code=00, pend_full=0, pend_code=00.
REQ-027 Output values during and after reset until first accept: D=0000, d_valid=0, busy=0; in_ready=0 while rst_n=0, 1 after release.
REQ-028 Reset mid-DRIVE or mid-GAP SHALL abort the current output and discard any pending code; no decoded output resumes.

Verification (HOLD=4 unless stated)
REQ-029 Single: A=10, v=1 for one cycle accepted at edge 1 -> D=0100, d_valid=1 cycles 2-5; D=0000 cycle 6; busy=0 cycle 7.
REQ-030 Back-to-back: A=00 then A=11, v held -> D=0001 x4, 0000 x1, 1000 x4, 0000 x1; in_ready=0 from cycle after second accept until GAP exit.
REQ-031 Backpressure: third code A=01 held with v=1 while pend_full -> not accepted until in_ready=1; then served after second code's GAP, D=0010 x4.
REQ-032 Reset mid-operation: rst_n=0 at second DRIVE cycle with pending code -> next cycle D=0000, d_valid=0, busy=0, pending lost.
REQ-033 HOLD=1: A=01 accepted edge 1 -> D=0010 cycle 2 only, 0000 cycle 3, busy=0 cycle 4.
REQ-034 Ignore: v=0 with A toggling, and v=1 during reset -> D stays 0000, busy stays 0.
